sseg_scan_scheduler: RTL
========================

# sseg_scan_scheduler

Time-multiplexed scan scheduler for the 8-digit common-anode seven-segment display on the board top level. It owns the `an`/`sseg` pins. It scans eight hex digits at a fixed refresh rate, commits new display contents atomically at frame boundaries, and optionally rotates the displayed pattern clockwise or counter-clockwise at a slower step rate. It sits between the application logic (which supplies `hex`/`dp`/`blank` plus a `load` strobe) and the board pins, driven from switch-level `en`/`cw` controls.

## Interface
- `REFRESH_DIV`, default 100_000: clocks per digit slot (1 kHz per digit at 100 MHz); minimum 4.
- `STEP_DIV`, default 50_000_000: clocks per rotation step while `en`=1; minimum 2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `hex`  in  32  eight nibbles; nibble k = `hex[4k+3:4k]`.
- `dp`  in  8  decimal point per nibble, 1 = lit.
- `blank`  in  8  per-nibble blank, 1 = dark.
- `load`  in  1  one-cycle strobe; captures `hex`/`dp`/`blank` into pending.
- `en`  in  1  rotation enable (level).
- `cw`  in  1  rotation direction, 1 = clockwise.
- `sseg`  out  8  active-low segments: bit7 = dp, bits6:0 = g..a.
- `an`  out  8  active-low digit enables, bit i = position i.
- `frame_start`  out  1  one-cycle pulse when scan index wraps to 0.
- `pending`  out  1  high while loaded data awaits commit.

## Operation
- Reset values: `an`=8'hFF, `sseg`=8'hFF, `frame_start`=0, `pending`=0. Refresh counter, step counter, scan index and offset are 0. Active and pending `hex`/`dp` are 0; active and pending `blank` are 8'hFF, so the display stays dark until the first commit.
- Refresh counter runs 0..REFRESH_DIV-1 and wraps. Its terminal count is the `tick`. On `tick`, scan index (3-bit) increments, wrapping 7->0.
- Dead time: the cycle after a scan-index change drives `an`=8'hFF and `sseg`=8'hFF (anti-ghosting). The following cycles drive the new digit.
- Position i displays source nibble s = (i + offset) mod 8.
- If active `blank[s]`=1, then `an`=8'hFF and `sseg`=8'hFF for that slot.
- Otherwise `an` = ~(1<<i), `sseg[7]` = ~dp[s], and `sseg[6:0]` = decode(nibble s).
- Decode, active-low, g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Load/commit:
  - `load` writes the pending registers and sets `pending`=1.
  - A second `load` before commit overwrites pending; last one wins.
  - Commit happens in the cycle the scan index wraps 7->0 (same cycle `frame_start` is high). At commit, pending copies to active and `pending` clears.
- Rotation:
  - Step counter advances only while `en`=1 and holds its value while `en`=0.
  - At terminal count STEP_DIV-1 it wraps and steps offset: +1 mod 8 if `cw`=1, -1 mod 8 if `cw`=0.
  - `cw` is sampled on the step cycle only.
- Simultaneous events:
  - `load` in the commit cycle: the older pending data commits, the new data becomes pending, and `pending` stays 1.
  - `load` in the commit cycle with `pending`=0: no commit this frame; the data commits at the next wrap.
  - A rotation step and a scan tick in the same cycle both take effect; the next displayed digit uses the new offset.
- Mid-operation `rst`: all state returns to reset values immediately; pending data is discarded.

## Timing
- All outputs are registered.
- `tick` at cycle T: scan index updates at T+1, outputs are dead (all 1s) during T+1, and the new digit appears at T+2.
- Scan frame = 8*REFRESH_DIV cycles. `frame_start` is high for exactly one cycle per frame, aligned with the index becoming 0.
- `load` at cycle T: `pending`=1 from T+1. Active contents change at the next wrap strictly after T.
- Offset change at step cycle T affects the digit index from T+1; the visible output updates at T+2.
- After `rst` deasserts, the first `tick` occurs REFRESH_DIV cycles later.

## Test plan
- **Reset, then load:** REFRESH_DIV=4. Reset, then load `hex`=32'h76543210, `blank`=0, `dp`=0. Required: all outputs 8'hFF until the first `frame_start`. `pending`=1 until the commit cycle, then 0. Position 0 then shows `an`=8'hFE with `sseg`=8'hC0, and position 7 shows `an`=8'h7F with `sseg`=8'hF8.
- **Dead time:** check every index change gives exactly one cycle of `an`=8'hFF. `frame_start` period = 32 cycles.
- **Rotation:** STEP_DIV=64, `en`=1, `cw`=1. After one step, position 0 shows digit 1 (`sseg`=8'hF9). Drop `en` for 100 cycles; offset does not change. With `cw`=0, two steps return offset to 7 (position 0 shows 7).
- **Blank/dp:** `blank`=8'h02, `dp`=8'h01. Position 1 slot has `an`=8'hFF. Position 0 shows `sseg`=8'h40.
- **Load collisions:**
  - Two loads (A then B) within one frame: only B is ever displayed.
  - Load C in the commit cycle with pending=B: B commits and C commits one frame later.
- **Reset mid-frame:** assert `rst` mid-frame with `pending`=1. Outputs go to 8'hFF asynchronously, and `pending`=0 on the same edge.

Source files
------------

// File: rtl/sseg_scan_scheduler.sv
// Eight-digit common-anode seven-segment scan scheduler with frame-aligned
// atomic commit of new contents and optional pattern rotation.
module sseg_scan_scheduler #(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned STEP_DIV    = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hex,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic        load,
  input  logic        en,
  input  logic        cw,
  output logic [7:0]  sseg,
  output logic [7:0]  an,
  output logic        frame_start,
  output logic        pending
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]    scan_idx_q, scan_idx_d;
  logic [2:0]    offset_q, offset_d;
  logic [31:0]   act_hex_q, act_hex_d, pend_hex_q, pend_hex_d;
  logic [7:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [7:0]    act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic          pending_q, pending_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    sseg_q, sseg_d;

  logic          tick;
  logic          wrap;
  logic [2:0]    src;
  logic [3:0]    nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Next-state for scan, rotation, load/commit and registered pin outputs.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    step_cnt_d    = step_cnt_q;
    scan_idx_d    = scan_idx_q;
    offset_d      = offset_q;
    act_hex_d     = act_hex_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    pend_hex_d    = pend_hex_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pending_d     = pending_q;
    frame_start_d = 1'b0;
    an_d          = 8'hFF;
    sseg_d        = 8'hFF;

    tick = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
    wrap = tick && (scan_idx_q == 3'd7);

    refresh_cnt_d = tick ? '0 : refresh_cnt_q + RW'(1);
    if (tick) scan_idx_d = scan_idx_q + 3'd1;
    frame_start_d = wrap;

    if (en) begin
      if (step_cnt_q == SW'(STEP_DIV - 1)) begin
        step_cnt_d = '0;
        offset_d   = cw ? offset_q + 3'd1 : offset_q - 3'd1;
      end else begin
        step_cnt_d = step_cnt_q + SW'(1);
      end
    end

    // Commit takes the data pending before this edge; a same-cycle load stays pending.
    if (wrap && pending_q) begin
      act_hex_d   = pend_hex_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      pending_d   = 1'b0;
    end
    if (load) begin
      pend_hex_d   = hex;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pending_d    = 1'b1;
    end

    src = scan_idx_q + offset_q;
    nib = act_hex_q[{src, 2'b00} +: 4];
    if (!tick && !act_blank_q[src]) begin
      an_d   = ~(8'd1 << scan_idx_q);
      sseg_d = {~act_dp_q[src], decode(nib)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      step_cnt_q    <= '0;
      scan_idx_q    <= 3'd0;
      offset_q      <= 3'd0;
      act_hex_q     <= 32'd0;
      act_dp_q      <= 8'd0;
      act_blank_q   <= 8'hFF;
      pend_hex_q    <= 32'd0;
      pend_dp_q     <= 8'd0;
      pend_blank_q  <= 8'hFF;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= 8'hFF;
      sseg_q        <= 8'hFF;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      step_cnt_q    <= step_cnt_d;
      scan_idx_q    <= scan_idx_d;
      offset_q      <= offset_d;
      act_hex_q     <= act_hex_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      pend_hex_q    <= pend_hex_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule
